// File: rtl/keypad_matrix_scanner_if.sv
// rtl/keypad_matrix_scanner_if.sv - key event stream between the scanner and its consumer
interface keypad_matrix_scanner_if #(
  parameter int CODE_W = 4
);
  logic [CODE_W-1:0] key_code;
  logic              key_release;
  logic              key_valid;
  logic              key_ready;

  modport master (output key_code, output key_release, output key_valid, input key_ready);
  modport slave  (input key_code, input key_release, input key_valid, output key_ready);
endinterface

// File: rtl/keypad_matrix_scanner.sv
// rtl/keypad_matrix_scanner.sv - matrix keypad scanner with debounce, ghost rejection and event FIFO
module keypad_matrix_scanner #(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int SCAN_DIV   = 1000,
  parameter int DB_SCANS   = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [ROWS-1:0]               row_n,
  output logic [COLS-1:0]               col_n,
  keypad_matrix_scanner_if.master       key_if,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic                          ghost,
  input  logic                          clr_overflow
);
  localparam int KEYS   = ROWS * COLS;
  localparam int CODE_W = $clog2(KEYS);
  localparam int DIV_W  = $clog2(SCAN_DIV);
  localparam int COL_W  = $clog2(COLS);
  localparam int DB_W   = $clog2(DB_SCANS);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int LVL_W  = PTR_W + 1;
  localparam int ENT_W  = CODE_W + 1;

  typedef enum logic {ST_IDLE, ST_WALK} walk_state_e;

  logic [ROWS-1:0]   row_s1_q, row_s1_d, row_s2_q, row_s2_d;
  logic [DIV_W-1:0]  dwell_q, dwell_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [KEYS-1:0]   snap_q, snap_d, snap_full;
  logic [KEYS-1:0]   prev_q, prev_d, stable_q, stable_d, diff_q, diff_d;
  logic [DB_W-1:0]   db_q, db_d;
  logic              ghost_q, ghost_d;
  walk_state_e       state_q, state_d;
  logic [CODE_W-1:0] idx_q, idx_d;
  logic [ENT_W-1:0]  mem_q [FIFO_DEPTH];
  logic [ENT_W-1:0]  mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_q, wr_d, rd_q, rd_d;
  logic [LVL_W-1:0]  lvl_q, lvl_d;
  logic              ovf_q, ovf_d;
  logic              dwell_end, scan_end, commit, push, pop, full, accept;

  function automatic logic [CODE_W:0] popcnt(input logic [KEYS-1:0] v);
    logic [CODE_W:0] n;
    n = '0;
    for (int i = 0; i < KEYS; i++) n = n + {{CODE_W{1'b0}}, v[i]};
    return n;
  endfunction

  // Scan timing, per-column sampling and whole-matrix debounce
  always_comb begin
    row_s1_d  = row_n;
    row_s2_d  = row_s1_q;
    dwell_end = (dwell_q == DIV_W'(SCAN_DIV - 1));
    scan_end  = dwell_end && (col_q == COL_W'(COLS - 1));
    dwell_d   = dwell_end ? '0 : dwell_q + 1'b1;
    col_d     = col_q;
    snap_full = snap_q;
    if (dwell_end) begin
      col_d = (col_q == COL_W'(COLS - 1)) ? '0 : col_q + 1'b1;
      for (int i = 0; i < KEYS; i++)
        if (COL_W'(i % COLS) == col_q) snap_full[i] = ~row_s2_q[i / COLS];
    end
    snap_d   = snap_full;
    prev_d   = prev_q;
    db_d     = db_q;
    ghost_d  = ghost_q;
    stable_d = stable_q;
    diff_d   = diff_q;
    commit   = 1'b0;
    if (scan_end) begin
      prev_d = snap_full;
      if (snap_full != prev_q)                 db_d = '0;
      else if (db_q != DB_W'(DB_SCANS - 1))    db_d = db_q + 1'b1;
      ghost_d = (popcnt(snap_full) > (CODE_W + 1)'(2));
      if ((db_d == DB_W'(DB_SCANS - 1)) && (snap_full != stable_q) && !ghost_d) begin
        commit   = 1'b1;
        stable_d = snap_full;
        diff_d   = snap_full ^ stable_q;
      end
    end
  end

  // Event walk: one key index per clock, ascending, after each commit
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    push    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (commit) begin
          state_d = ST_WALK;
          idx_d   = '0;
        end
      end
      ST_WALK: begin
        push = diff_q[idx_q];
        if (idx_q == CODE_W'(KEYS - 1)) state_d = ST_IDLE;
        else                            idx_d   = idx_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A simultaneous pop frees the slot, so a push at full is still accepted
  always_comb begin
    full   = (lvl_q == LVL_W'(FIFO_DEPTH));
    pop    = key_if.key_valid && key_if.key_ready;
    accept = push && (!full || pop);
    mem_d  = mem_q;
    wr_d   = wr_q;
    rd_d   = rd_q;
    lvl_d  = lvl_q;
    ovf_d  = ovf_q;
    if (accept) begin
      mem_d[wr_q] = {idx_q, ~stable_q[idx_q]};
      wr_d        = wr_q + 1'b1;
    end
    if (pop) rd_d = rd_q + 1'b1;
    if (accept && !pop)      lvl_d = lvl_q + 1'b1;
    else if (!accept && pop) lvl_d = lvl_q - 1'b1;
    if (push && !accept) ovf_d = 1'b1;
    if (clr_overflow)    ovf_d = 1'b0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      row_s1_q <= '1;
      row_s2_q <= '1;
      dwell_q  <= '0;
      col_q    <= '0;
      snap_q   <= '0;
      prev_q   <= '0;
      stable_q <= '0;
      diff_q   <= '0;
      db_q     <= '0;
      ghost_q  <= 1'b0;
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_q     <= '0;
      rd_q     <= '0;
      lvl_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      row_s1_q <= row_s1_d;
      row_s2_q <= row_s2_d;
      dwell_q  <= dwell_d;
      col_q    <= col_d;
      snap_q   <= snap_d;
      prev_q   <= prev_d;
      stable_q <= stable_d;
      diff_q   <= diff_d;
      db_q     <= db_d;
      ghost_q  <= ghost_d;
      state_q  <= state_d;
      idx_q    <= idx_d;
      mem_q    <= mem_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      lvl_q    <= lvl_d;
      ovf_q    <= ovf_d;
    end
  end

  assign col_n              = ~(COLS'(1) << col_q);
  assign key_if.key_valid   = (lvl_q != '0);
  assign key_if.key_code    = mem_q[rd_q][ENT_W-1:1];
  assign key_if.key_release = mem_q[rd_q][0];
  assign fifo_level         = lvl_q;
  assign overflow           = ovf_q;
  assign ghost              = ghost_q;
endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// tb/tb_keypad_matrix_scanner.sv - self-checking bench for keypad_matrix_scanner (4x4, 16-clock dwell)
module tb_keypad_matrix_scanner;
  localparam int SCAN_CLKS = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  row_n;
  logic [3:0]  col_n;
  logic [2:0]  fifo_level;
  logic        overflow, ghost;
  logic        clr_overflow = 1'b0;
  logic [15:0] keys = '0;
  int          since_rst = 0;
  int          checks = 0;
  int          errors = 0;
  logic [4:0]  got [$];
  logic [4:0]  expq [$];
  logic [15:0] m_prev, m_stable;
  int          m_db;
  logic        m_ghost;

  typedef struct {
    logic [15:0]     keys;
    int              scans;
    logic            ghost;
    int              n_ev;
    logic [3:0][4:0] ev;
  } vec_t;
  vec_t tbl [$];

  keypad_matrix_scanner_if #(.CODE_W(4)) kif ();

  keypad_matrix_scanner #(
    .ROWS(4), .COLS(4), .SCAN_DIV(16), .DB_SCANS(3), .FIFO_DEPTH(4)
  ) dut (
    .clock(clk), .reset(rst_n), .row_n(row_n), .col_n(col_n), .key_if(kif.master),
    .fifo_level(fifo_level), .overflow(overflow), .ghost(ghost), .clr_overflow(clr_overflow)
  );

  always #5 clk = ~clk;

  // Physical keypad: a held key pulls its row low while its column is driven
  always_comb begin
    row_n = '1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!col_n[c] && keys[r*4+c]) row_n[r] = 1'b0;
  end

  always @(posedge clk) since_rst <= rst_n ? since_rst + 1 : 0;

  always @(negedge clk)
    if (kif.key_valid && kif.key_ready) got.push_back({kif.key_release, kif.key_code});

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic cmp_events(input string nm);
    chk({nm, " count"}, got.size(), expq.size());
    for (int i = 0; i < got.size() && i < expq.size(); i++)
      chk($sformatf("%s ev%0d", nm, i), got[i], expq[i]);
    got.delete();
    expq.delete();
  endtask

  // Scan-level reference: one call per completed full-matrix scan
  task automatic model_scan(input logic [15:0] s);
    m_db    = (s == m_prev) ? ((m_db < 2) ? m_db + 1 : 2) : 0;
    m_prev  = s;
    m_ghost = ($countones(s) > 2);
    if (m_db == 2 && s != m_stable && !m_ghost) begin
      for (int i = 0; i < 16; i++)
        if (s[i] != m_stable[i]) expq.push_back({~s[i], 4'(i)});
      m_stable = s;
    end
  endtask

  task automatic run_scans(input int n, input bit use_model);
    for (int s = 0; s < n; s++) begin
      do begin @(posedge clk); #1; end while (since_rst % SCAN_CLKS != 0);
      if (use_model) begin
        model_scan(keys);
        chk("ghost model", ghost, m_ghost);
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic add(input logic [15:0] k, input int s, input logic g, input int n, input logic [19:0] ev);
    vec_t v;
    v.keys = k; v.scans = s; v.ghost = g; v.n_ev = n; v.ev = ev;
    tbl.push_back(v);
  endtask

  initial begin
    logic [3:0] bit_i;
    int         nk;
    kif.key_ready = 1'b1;

    add(16'h0000, 6, 1'b0, 1, {15'h0, 5'h16});
    for (int t = 0; t < 10; t++) add((t % 2 == 0) ? 16'h0001 : 16'h0000, 1, 1'b0, 0, 20'h0);
    add(16'h4002, 6, 1'b0, 2, {10'h0, 5'h0E, 5'h01});
    add(16'h0000, 6, 1'b0, 2, {10'h0, 5'h1E, 5'h11});
    add(16'h0421, 6, 1'b1, 0, 20'h0);
    add(16'h0021, 6, 1'b0, 2, {10'h0, 5'h05, 5'h00});
    add(16'h0000, 6, 1'b0, 2, {10'h0, 5'h15, 5'h10});

    repeat (3) @(posedge clk);
    #1;
    chk("rst col_n", col_n, 4'hE);
    chk("rst key_valid", kif.key_valid, 0);
    chk("rst fifo_level", fifo_level, 0);
    chk("rst overflow", overflow, 0);
    chk("rst ghost", ghost, 0);
    chk("rst key_code", {kif.key_release, kif.key_code}, 0);
    rst_n = 1'b1;

    keys = 16'h0040;
    run_scans(3, 1'b0);
    repeat (8) @(posedge clk);
    #1;
    chk("t1 valid latency", got.size(), 1);
    run_scans(3, 1'b0);
    expq.push_back(5'h06);
    cmp_events("t1 press");

    foreach (tbl[i]) begin
      keys = tbl[i].keys;
      run_scans(tbl[i].scans, 1'b0);
      chk($sformatf("row%0d ghost", i), ghost, tbl[i].ghost);
      chk($sformatf("row%0d level", i), fifo_level, 0);
      for (int e = 0; e < tbl[i].n_ev; e++) expq.push_back(tbl[i].ev[e]);
      cmp_events($sformatf("row%0d", i));
    end

    kif.key_ready = 1'b0;
    keys = 16'h0003; run_scans(6, 1'b0);
    keys = 16'h0000; run_scans(6, 1'b0);
    chk("t5 level full", fifo_level, 4);
    chk("t5 ovf clear", overflow, 0);
    keys = 16'h0004; run_scans(6, 1'b0);
    chk("t5 level held", fifo_level, 4);
    chk("t5 ovf set", overflow, 1);
    chk("t5 head", {kif.key_release, kif.key_code}, 5'h00);
    kif.key_ready = 1'b1;
    run_scans(1, 1'b0);
    chk("t5 ovf sticky", overflow, 1);
    expq = '{5'h00, 5'h01, 5'h10, 5'h11};
    cmp_events("t5");
    clr_overflow = 1'b1;
    @(posedge clk); #1;
    clr_overflow = 1'b0;
    chk("t5 ovf cleared", overflow, 0);

    kif.key_ready = 1'b0;
    keys = 16'h0000; run_scans(6, 1'b0);
    keys = 16'h0080; run_scans(6, 1'b0);
    keys = 16'h0180; run_scans(6, 1'b0);
    keys = 16'h0100; run_scans(6, 1'b0);
    chk("t6 level full", fifo_level, 4);
    keys = 16'h0101; run_scans(3, 1'b0);
    kif.key_ready = 1'b1;
    run_scans(3, 1'b0);
    chk("t6 ovf", overflow, 0);
    chk("t6 level", fifo_level, 0);
    expq = '{5'h12, 5'h07, 5'h08, 5'h17, 5'h00};
    cmp_events("t6 full walk");

    keys = 16'h8001; run_scans(3, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6 rst key_valid", kif.key_valid, 0);
    chk("t6 rst level", fifo_level, 0);
    chk("t6 rst col_n", col_n, 4'hE);
    @(negedge clk);
    chk("t6 rst col_n edge", col_n, 4'hE);
    expq.push_back(5'h18);
    cmp_events("t6 pre-reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_scans(6, 1'b0);
    expq = '{5'h00, 5'h0F};
    cmp_events("t6 after reset");

    do_reset();
    m_prev = '0; m_stable = '0; m_db = 0; m_ghost = 1'b0;
    got.delete(); expq.delete();
    keys = '0;
    for (int seg = 0; seg < 24; seg++) begin
      if ($urandom_range(0, 3) != 0) begin
        keys = '0;
        nk = $urandom_range(0, 3);
        for (int k = 0; k < nk; k++) begin
          bit_i = 4'($urandom_range(0, 15));
          keys[bit_i] = 1'b1;
        end
      end
      run_scans($urandom_range(1, 5), 1'b1);
    end
    run_scans(4, 1'b1);
    cmp_events("random");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
